// File: rtl/pcs_block_lock_ctrl.sv
// Purpose : 66b block-lock controller; checks sync headers, slips the gearbox until locked.
// Latency : blk_lock changes the cycle after the deciding header; slip pulses two cycles after it.
// Backpressure: none; hdr_valid may gap, idle cycles leave the window untouched.
//
// Ports:
//   clk156, rstb156        core clock, asynchronous active-low reset
//   signal_ok              PMA signal detect; low restarts acquisition
//   hdr_valid, sync_hdr    qualified 2-bit sync header of the current 66b block
//   slip                   one-cycle request to shift gearbox alignment by one bit
//   blk_lock               block lock indication
//   sh_invld_cnt_o         invalid-header count of the current window (debug)
// Optional build macro LOCK_STATS_EN adds slip_cnt[15:0] and lock_loss_cnt[7:0]
// (saturating counts of slip pulses and of header-induced lock losses).
module pcs_block_lock_ctrl #(
    parameter int SH_WIN       = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32
) (
    input  logic                          clk156,
    input  logic                          rstb156,
    input  logic                          signal_ok,
    input  logic                          hdr_valid,
    input  logic [1:0]                    sync_hdr,
    output logic                          slip,
    output logic                          blk_lock,
    output logic [$clog2(SH_INVLD_MAX):0] sh_invld_cnt_o
`ifdef LOCK_STATS_EN
    ,
    output logic [15:0]                   slip_cnt,
    output logic [7:0]                    lock_loss_cnt
`endif
);

    localparam int SH_CNT_W = $clog2(SH_WIN) + 1;
    localparam int INV_W    = $clog2(SH_INVLD_MAX) + 1;
    localparam int WAIT_W   = 8;

    localparam logic [SH_CNT_W-1:0] SH_WIN_L       = SH_CNT_W'(SH_WIN);
    localparam logic [INV_W-1:0]    INV_MAX_L      = INV_W'(SH_INVLD_MAX);
    localparam logic [WAIT_W-1:0]   WAIT_LAST_L    = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_LOCK_INIT,
        ST_TEST_SH,
        ST_SLIP,
        ST_SLIP_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [SH_CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]      invld_q, invld_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  blk_lock_q, blk_lock_d;
    logic                  slip_q, slip_d;

    logic                  hdr_ok;
    logic [SH_CNT_W-1:0]   sh_cnt_inc;
    logic [INV_W-1:0]      invld_inc;

`ifdef LOCK_STATS_EN
    logic [15:0]           slip_cnt_q, slip_cnt_d;
    logic [7:0]            lock_loss_cnt_q, lock_loss_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        invld_d    = invld_q;
        wait_d     = wait_q;
        blk_lock_d = blk_lock_q;
        slip_d     = 1'b0;
`ifdef LOCK_STATS_EN
        slip_cnt_d      = slip_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
`endif

        // 01 and 10 are the only legal sync headers.
        hdr_ok     = sync_hdr[1] ^ sync_hdr[0];
        sh_cnt_inc = sh_cnt_q + SH_CNT_W'(1);
        invld_inc  = (invld_q == INV_MAX_L) ? invld_q : invld_q + INV_W'(1);

        if (!signal_ok) begin
            // Loss of signal overrides everything, including a slip about to fire.
            state_d    = ST_LOCK_INIT;
            blk_lock_d = 1'b0;
            sh_cnt_d   = '0;
            invld_d    = '0;
            wait_d     = '0;
        end else begin
            case (state_q)
                ST_LOCK_INIT: begin
                    blk_lock_d = 1'b0;
                    sh_cnt_d   = '0;
                    invld_d    = '0;
                    wait_d     = '0;
                    state_d    = ST_TEST_SH;
                end

                ST_TEST_SH: begin
                    if (hdr_valid) begin
                        if (!hdr_ok && !blk_lock_q) begin
                            // Any bad header while hunting means wrong alignment.
                            state_d  = ST_SLIP;
                            sh_cnt_d = '0;
                            invld_d  = '0;
                        end else if (!hdr_ok && (invld_inc == INV_MAX_L)) begin
                            // Checked before window completion so loss of lock wins a tie.
                            blk_lock_d = 1'b0;
                            state_d    = ST_SLIP;
                            sh_cnt_d   = '0;
                            invld_d    = '0;
`ifdef LOCK_STATS_EN
                            if (lock_loss_cnt_q != 8'hFF) begin
                                lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                            end
`endif
                        end else if (sh_cnt_inc == SH_WIN_L) begin
                            // Window done: unlocked implies every header was good.
                            blk_lock_d = 1'b1;
                            sh_cnt_d   = '0;
                            invld_d    = '0;
                        end else begin
                            sh_cnt_d = sh_cnt_inc;
                            invld_d  = hdr_ok ? invld_q : invld_inc;
                        end
                    end
                end

                ST_SLIP: begin
                    slip_d     = 1'b1;
                    blk_lock_d = 1'b0;
                    wait_d     = '0;
                    state_d    = ST_SLIP_WAIT;
                end

                ST_SLIP_WAIT: begin
                    // Headers are ignored while the gearbox settles on the new alignment.
                    if (wait_q == WAIT_LAST_L) begin
                        state_d  = ST_TEST_SH;
                        wait_d   = '0;
                        sh_cnt_d = '0;
                        invld_d  = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end

                default: begin
                    state_d    = ST_LOCK_INIT;
                    blk_lock_d = 1'b0;
                end
            endcase
        end

`ifdef LOCK_STATS_EN
        if (slip_d && (slip_cnt_q != 16'hFFFF)) begin
            slip_cnt_d = slip_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk156 or negedge rstb156) begin
        if (!rstb156) begin
            state_q    <= ST_LOCK_INIT;
            sh_cnt_q   <= '0;
            invld_q    <= '0;
            wait_q     <= '0;
            blk_lock_q <= 1'b0;
            slip_q     <= 1'b0;
`ifdef LOCK_STATS_EN
            slip_cnt_q      <= '0;
            lock_loss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            invld_q    <= invld_d;
            wait_q     <= wait_d;
            blk_lock_q <= blk_lock_d;
            slip_q     <= slip_d;
`ifdef LOCK_STATS_EN
            slip_cnt_q      <= slip_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
`endif
        end
    end

    assign slip           = slip_q;
    assign blk_lock       = blk_lock_q;
    assign sh_invld_cnt_o = (state_q == ST_TEST_SH) ? invld_q : '0;

`ifdef LOCK_STATS_EN
    assign slip_cnt      = slip_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// Purpose : self-checking bench for pcs_block_lock_ctrl against a timestamp-based reference model.
// Latency : model predicts outputs visible just after each clk156 rising edge.
// Backpressure: not applicable; stimulus drives hdr_valid with gaps and random headers.
module tb_pcs_block_lock_ctrl;

    localparam int SH_WIN       = 64;
    localparam int SH_INVLD_MAX = 16;
    localparam int SLIP_WAIT    = 32;

    logic       clk156 = 1'b0;
    logic       rstb156;
    logic       signal_ok;
    logic       hdr_valid;
    logic [1:0] sync_hdr;
    logic       slip;
    logic       blk_lock;
    logic [4:0] sh_invld_cnt_o;
`ifdef LOCK_STATS_EN
    logic [15:0] slip_cnt;
    logic [7:0]  lock_loss_cnt;
`endif

    pcs_block_lock_ctrl #(
        .SH_WIN       (SH_WIN),
        .SH_INVLD_MAX (SH_INVLD_MAX),
        .SLIP_WAIT    (SLIP_WAIT)
    ) dut (
        .clk156         (clk156),
        .rstb156        (rstb156),
        .signal_ok      (signal_ok),
        .hdr_valid      (hdr_valid),
        .sync_hdr       (sync_hdr),
        .slip           (slip),
        .blk_lock       (blk_lock),
        .sh_invld_cnt_o (sh_invld_cnt_o)
`ifdef LOCK_STATS_EN
        ,
        .slip_cnt       (slip_cnt),
        .lock_loss_cnt  (lock_loss_cnt)
`endif
    );

    always #5 clk156 = ~clk156;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: tracks edge numbers at which events are due rather than states.
    int edge_n;          // index of the next modelled clock edge
    int m_active_from;   // first edge whose header is evaluated
    int m_slip_edge;     // edge after which slip must be seen high (-1: none)
    int m_hdrs;          // headers in current window
    int m_bad;           // invalid headers in current window
    int m_slips;
    int m_losses;
    bit m_lock;
    bit m_exp_slip;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active_from = edge_n + 1;
        m_slip_edge   = -1;
        m_hdrs        = 0;
        m_bad         = 0;
        m_slips       = 0;
        m_losses      = 0;
        m_lock        = 1'b0;
        m_exp_slip    = 1'b0;
    endtask

    task automatic model_step(input bit sok, input bit hv, input logic [1:0] sh);
        int e;
        bit good;
        e    = edge_n;
        good = (sh == 2'b01) || (sh == 2'b10);
        m_exp_slip = sok && (m_slip_edge == e);
        if (m_exp_slip && m_slips < 65535) m_slips++;
        if (m_slip_edge <= e) m_slip_edge = -1;
        if (!sok) begin
            m_lock        = 1'b0;
            m_hdrs        = 0;
            m_bad         = 0;
            m_active_from = e + 2;
        end else if (hv && e >= m_active_from) begin
            m_hdrs++;
            if (!good) m_bad++;
            if (!good && (!m_lock || m_bad == SH_INVLD_MAX)) begin
                if (m_lock && m_losses < 255) m_losses++;
                m_lock        = 1'b0;
                m_hdrs        = 0;
                m_bad         = 0;
                m_slip_edge   = e + 1;
                m_active_from = e + 2 + SLIP_WAIT;
            end else if (m_hdrs == SH_WIN) begin
                m_lock = 1'b1;
                m_hdrs = 0;
                m_bad  = 0;
            end
        end
        edge_n++;
    endtask

    task automatic cycle(input bit sok, input bit hv, input logic [1:0] sh);
        signal_ok = sok;
        hdr_valid = hv;
        sync_hdr  = sh;
        @(posedge clk156);
        #1;
        model_step(sok, hv, sh);
        chk("slip", 32'(slip), 32'(m_exp_slip));
        chk("blk_lock", 32'(blk_lock), 32'(m_lock));
        chk("sh_invld_cnt", 32'(sh_invld_cnt_o), 32'(m_bad));
`ifdef LOCK_STATS_EN
        chk("slip_cnt", 32'(slip_cnt), 32'(m_slips));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_losses));
`endif
    endtask

    task automatic do_reset();
        #2 rstb156 = 1'b0;
        #1;
        chk("rst_slip", 32'(slip), 32'd0);
        chk("rst_blk_lock", 32'(blk_lock), 32'd0);
        chk("rst_invld", 32'(sh_invld_cnt_o), 32'd0);
        @(posedge clk156);
        @(negedge clk156);
        rstb156 = 1'b1;
        model_reset();
    endtask

    function automatic logic [1:0] vhdr();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] ihdr();
        return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    endfunction

    initial begin
        bit pos [64];
        int cnt;
        int p;
        int slips_seen;
        int first_off;
        int peak;
        int rate;

        edge_n    = 0;
        rstb156   = 1'b1;
        signal_ok = 1'b0;
        hdr_valid = 1'b0;
        sync_hdr  = 2'b00;
        #1 rstb156 = 1'b0;
        #2;
        chk("reset_slip", 32'(slip), 32'd0);
        chk("reset_blk_lock", 32'(blk_lock), 32'd0);
        chk("reset_invld", 32'(sh_invld_cnt_o), 32'd0);
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        rstb156 = 1'b1;
        model_reset();

        // Acquisition from 64 consecutive good headers.
        cycle(1, 0, 2'b00);
        slips_seen = 0;
        for (int i = 0; i < SH_WIN; i++) begin
            cycle(1, 1, vhdr());
            if (slip) slips_seen++;
        end
        chk("lock_after_64", 32'(blk_lock), 32'd1);
        chk("no_slip_acq", 32'(slips_seen), 32'd0);

        // Locked: 15 bad headers spread over one window keep the lock.
        foreach (pos[i]) pos[i] = 1'b0;
        cnt = 0;
        while (cnt < SH_INVLD_MAX - 1) begin
            p = $urandom_range(0, SH_WIN - 2);
            if (!pos[p]) begin pos[p] = 1'b1; cnt++; end
        end
        peak = 0;
        for (int i = 0; i < SH_WIN; i++) begin
            cycle(1, 1, pos[i] ? ihdr() : vhdr());
            if (int'(sh_invld_cnt_o) > peak) peak = int'(sh_invld_cnt_o);
        end
        chk("peak_invld_15", 32'(peak), 32'd15);
        chk("lock_kept_15", 32'(blk_lock), 32'd1);
        chk("invld_clr_window", 32'(sh_invld_cnt_o), 32'd0);

        // Locked: 16th bad header in a window drops lock and slips once.
        foreach (pos[i]) pos[i] = 1'b0;
        cnt = 0;
        while (cnt < SH_INVLD_MAX) begin
            p = $urandom_range(0, 29);
            if (!pos[p]) begin pos[p] = 1'b1; cnt++; end
        end
        slips_seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1, 1, pos[i] ? ihdr() : vhdr());
            if (slip) slips_seen++;
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 2'b00);
            if (slip) slips_seen++;
        end
        chk("loss_slips", 32'(slips_seen), 32'd1);
        chk("loss_unlocked", 32'(blk_lock), 32'd0);

        // Unlocked: bad 10th header slips two cycles later; wait ignores bad headers.
        for (int i = 0; i < 9; i++) cycle(1, 1, vhdr());
        cycle(1, 1, 2'b11);
        slips_seen = 0;
        first_off  = -1;
        for (int i = 1; i <= SLIP_WAIT + 1; i++) begin
            cycle(1, 1, ihdr());
            if (slip) begin
                slips_seen++;
                if (first_off < 0) first_off = i;
            end
        end
        chk("slip_delay", 32'(first_off), 32'd1);
        chk("slip_once_in_wait", 32'(slips_seen), 32'd1);
        for (int i = 0; i < SH_WIN; i++) cycle(1, 1, vhdr());
        chk("relock_after_wait", 32'(blk_lock), 32'd1);

        // Locked: one-cycle signal_ok drop mid-window, no slip.
        for (int i = 0; i < 20; i++) cycle(1, 1, vhdr());
        slips_seen = 0;
        cycle(0, 1, vhdr());
        chk("sigdrop_unlock", 32'(blk_lock), 32'd0);
        cycle(1, 0, 2'b00);
        if (slip) slips_seen++;
        // Re-acquire with headers on every other cycle; idle cycles carry junk.
        for (int i = 0; i < SH_WIN; i++) begin
            cycle(1, 1, vhdr());
            if (slip) slips_seen++;
            if (i == SH_WIN - 1) chk("gap_lock_64", 32'(blk_lock), 32'd1);
            cycle(1, 0, ihdr());
            if (slip) slips_seen++;
        end
        chk("sigdrop_no_slip", 32'(slips_seen), 32'd0);
        chk("gap_lock_held", 32'(blk_lock), 32'd1);

        // Random segments with varying error density and rare signal loss.
        for (int s = 0; s < 12; s++) begin
            rate = $urandom_range(0, 2);
            for (int i = 0; i < 250; i++) begin
                bit bad;
                bad = (rate == 1) ? ($urandom_range(0, 39) == 0) :
                      (rate == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
                cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
                      bad ? ihdr() : vhdr());
            end
        end

        // Reset while locked with a non-zero invalid count.
        cycle(0, 0, 2'b00);
        cycle(1, 0, 2'b00);
        for (int i = 0; i < SH_WIN; i++) cycle(1, 1, vhdr());
        cycle(1, 1, 2'b00);
        cycle(1, 1, vhdr());
        cycle(1, 1, 2'b11);
        chk("pre_rst_invld", 32'(sh_invld_cnt_o), 32'd2);
        do_reset();

        // Reset during the slip wait, while slip is high.
        cycle(1, 0, 2'b00);
        cycle(1, 1, 2'b00);
        cycle(1, 1, vhdr());
        chk("pre_rst_slip", 32'(slip), 32'd1);
        do_reset();
        cycle(1, 0, 2'b00);
        for (int i = 0; i < SH_WIN; i++) cycle(1, 1, vhdr());
        chk("lock_after_reset", 32'(blk_lock), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
